// File: rtl/digital_tube_drv.sv
// Memory-mapped 8-digit hex display driver: two time-multiplexed 4-digit active-low 7-segment groups.
// Latency: a register write at edge N shows on the segment/select outputs at edge N+1; readback is combinational.
// Backpressure: none, writes are accepted every cycle. Optional DIGITAL_TUBE_LZB_EN enables leading-zero blanking.
module digital_tube_drv #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] Din,
    output logic [31:0] TUBE_Dout,
    output logic [7:0]  digital_tube0,
    output logic [3:0]  digital_tube_sel0,
    output logic [7:0]  digital_tube1,
    output logic [3:0]  digital_tube_sel1
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [31:0]      data;
    logic             en;

    logic [3:0]       nib0;
    logic [3:0]       nib1;
    logic [7:0]       seg0_nxt;
    logic [7:0]       seg1_nxt;
    logic [3:0]       sel_nxt;

    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Scan counters free-run independently of EN so re-enabling resumes mid-scan.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            idx  <= 2'd0;
            data <= 32'd0;
            en   <= 1'b1;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (WE) begin
                if (!Addr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (BE[i]) data[8*i +: 8] <= Din[8*i +: 8];
                    end
                end else if (BE[0]) begin
                    en <= Din[0];
                end
            end
        end
    end

    always_comb begin
        nib0     = data[{idx, 2'b00} +: 4];
        nib1     = data[{1'b1, idx, 2'b00} +: 4];
        seg0_nxt = hex2seg(nib0);
        seg1_nxt = hex2seg(nib1);
        sel_nxt  = ~(4'b0001 << idx);
`ifdef DIGITAL_TUBE_LZB_EN
        // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
        if ((idx != 2'd0) && ((data >> {idx, 2'b00}) == 32'd0)) seg0_nxt = 8'hFF;
        if ((data >> {1'b1, idx, 2'b00}) == 32'd0) seg1_nxt = 8'hFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            digital_tube0     <= 8'hFF;
            digital_tube_sel0 <= 4'hF;
            digital_tube1     <= 8'hFF;
            digital_tube_sel1 <= 4'hF;
        end else begin
            digital_tube0     <= seg0_nxt;
            digital_tube_sel0 <= sel_nxt;
            digital_tube1     <= seg1_nxt;
            digital_tube_sel1 <= sel_nxt;
        end
    end

    assign TUBE_Dout = Addr ? {31'd0, en} : data;

endmodule

// File: tb/tb_digital_tube_drv.sv
// Bench for digital_tube_drv: directed scenarios plus randomized bus traffic checked against a cycle-count model.
module tb_digital_tube_drv;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        Addr;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] Din;
    logic [31:0] TUBE_Dout;
    logic [7:0]  digital_tube0;
    logic [3:0]  digital_tube_sel0;
    logic [7:0]  digital_tube1;
    logic [3:0]  digital_tube_sel1;

    digital_tube_drv #(.SCAN_DIV(SD)) dut (
        .clk               (clk),
        .reset             (reset),
        .Addr              (Addr),
        .WE                (WE),
        .BE                (BE),
        .Din               (Din),
        .TUBE_Dout         (TUBE_Dout),
        .digital_tube0     (digital_tube0),
        .digital_tube_sel0 (digital_tube_sel0),
        .digital_tube1     (digital_tube1),
        .digital_tube_sel1 (digital_tube_sel1)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_data;
    logic        m_en;
    int          m_t;
    int          shown_idx;
    logic [7:0]  e_t0, e_t1;
    logic [3:0]  e_s0, e_s1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Segment pattern for global digit k (0..7) of value d.
    function automatic logic [7:0] ref_seg(input int k, input logic [31:0] d);
        logic [31:0] rest;
        rest = d >> (4 * k);
`ifdef DIGITAL_TUBE_LZB_EN
        if (k != 0 && rest == 32'd0) return 8'hFF;
`endif
        return seg_lut[rest[3:0]];
    endfunction

    // One clock edge: predict outputs from pre-edge state, update the model, then compare.
    task automatic step();
        int k;
        @(posedge clk);
        if (reset) begin
            e_t0 = 8'hFF; e_t1 = 8'hFF; e_s0 = 4'hF; e_s1 = 4'hF;
            m_data = 32'd0; m_en = 1'b1; m_t = 0; shown_idx = -1;
        end else begin
            k = (m_t / SD) % 4;
            shown_idx = m_en ? k : -1;
            if (m_en) begin
                e_t0 = ref_seg(k, m_data);
                e_t1 = ref_seg(4 + k, m_data);
                e_s0 = ~(4'b0001 << k);
                e_s1 = e_s0;
            end else begin
                e_t0 = 8'hFF; e_t1 = 8'hFF; e_s0 = 4'hF; e_s1 = 4'hF;
            end
            if (WE) begin
                if (!Addr) begin
                    for (int b = 0; b < 4; b++)
                        if (BE[b]) m_data[8*b +: 8] = Din[8*b +: 8];
                end else if (BE[0]) begin
                    m_en = Din[0];
                end
            end
            m_t++;
        end
        #1;
        chk("tube0", digital_tube0, e_t0);
        chk("sel0", digital_tube_sel0, e_s0);
        chk("tube1", digital_tube1, e_t1);
        chk("sel1", digital_tube_sel1, e_s1);
        chk("dout", TUBE_Dout, Addr ? {31'd0, m_en} : m_data);
    endtask

    task automatic wr(input logic a, input logic [3:0] be, input logic [31:0] d);
        Addr = a; BE = be; Din = d; WE = 1'b1;
        step();
        WE = 1'b0;
    endtask

    // Advance at least one edge, until the outputs show digit slot k.
    task automatic wait_shown(input int k);
        int n = 0;
        do begin
            step();
            n++;
        end while (shown_idx != k && n < 40);
        chk("sync_idx", shown_idx, k);
    endtask

    initial begin
        int n;
        reset = 1'b1; Addr = 1'b0; WE = 1'b0; BE = 4'h0; Din = 32'd0;
        step();
        step();
        chk("rst_tube0_off", digital_tube0, 8'hFF);
        chk("rst_sel0_off", digital_tube_sel0, 4'hF);
        reset = 1'b0;

        // Reset state readback and first digit
        step();
        chk("t1_dout0", TUBE_Dout, 32'd0);
        Addr = 1'b1; #1;
        chk("t1_dout1", TUBE_Dout, 32'd1);
        Addr = 1'b0;
        wait_shown(0);
        chk("t1_sel0", digital_tube_sel0, 4'hE);
        chk("t1_tube0", digital_tube0, 8'hC0);
`ifdef DIGITAL_TUBE_LZB_EN
        chk("t1_tube1", digital_tube1, 8'hFF);
`else
        chk("t1_tube1", digital_tube1, 8'hC0);
`endif

        // Full-word write
        wr(1'b0, 4'hF, 32'h12345678);
        wait_shown(0);
        chk("t2_i0_tube0", digital_tube0, 8'h80);
        chk("t2_i0_tube1", digital_tube1, 8'h99);
        wait_shown(1);
        chk("t2_i1_sel0", digital_tube_sel0, 4'hD);
        chk("t2_i1_tube0", digital_tube0, 8'hF8);
        chk("t2_i1_tube1", digital_tube1, 8'hB0);
        wait_shown(3);
        chk("t2_i3_sel1", digital_tube_sel1, 4'h7);
        chk("t2_i3_tube0", digital_tube0, 8'h92);
        chk("t2_i3_tube1", digital_tube1, 8'hF9);

        // Byte-enable partial write
        wr(1'b0, 4'b0010, 32'h0000AB00);
        chk("t3_dout", TUBE_Dout, 32'h1234AB78);
        wait_shown(1);
        chk("t3_i1_tube0", digital_tube0, 8'hF8);
        wait_shown(2);
        chk("t3_i2_tube0", digital_tube0, 8'h83);

        // Display disable / enable
        wr(1'b1, 4'h1, 32'd0);
        chk("t4_dout1", TUBE_Dout, 32'd0);
        step();
        chk("t4_tube0_off", digital_tube0, 8'hFF);
        chk("t4_sel0_off", digital_tube_sel0, 4'hF);
        chk("t4_tube1_off", digital_tube1, 8'hFF);
        chk("t4_sel1_off", digital_tube_sel1, 4'hF);
        wr(1'b1, 4'h1, 32'd1);
        step();
        chk("t4_resume", digital_tube_sel0 == 4'hF, 1'b0);
        Addr = 1'b0;

        // Mid-scan reset at idx2, cnt1
        n = 0;
        while (m_t % 16 != 9 && n < 40) begin
            step();
            n++;
        end
        chk("t5_reach", m_t % 16, 9);
        reset = 1'b1;
        step();
        chk("t5_tube0_off", digital_tube0, 8'hFF);
        chk("t5_sel1_off", digital_tube_sel1, 4'hF);
        reset = 1'b0;
        step();
        chk("t5_sel0", digital_tube_sel0, 4'hE);
        chk("t5_tube0", digital_tube0, 8'hC0);
        chk("t5_dout", TUBE_Dout, 32'd0);

        // Leading zeros
        wr(1'b0, 4'hF, 32'h000000A0);
        wait_shown(2);
        chk("t6_sel0", digital_tube_sel0, 4'hB);
`ifdef DIGITAL_TUBE_LZB_EN
        chk("t6_tube0", digital_tube0, 8'hFF);
`else
        chk("t6_tube0", digital_tube0, 8'hC0);
`endif
        wait_shown(1);
        chk("t6_i1_tube0", digital_tube0, 8'h88);

        // Randomized bus traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 200) == 0;
            WE    = ($urandom % 3) == 0;
            Addr  = ($urandom % 4) == 0;
            BE    = 4'($urandom);
            case ($urandom % 3)
                0: Din = $urandom;
                1: Din = $urandom >> $urandom_range(4, 31);
                default: Din = 32'h1 << $urandom_range(0, 31);
            endcase
            if (Addr) Din[0] = ($urandom % 4) != 0;
            step();
        end
        reset = 1'b0; WE = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
